apb_slave_regs: RTL and testbench
=================================

// Module: apb_slave_regs
// PURPOSE
// - APB2 responder at the far end of the AHB-to-APB bridge: decodes one Pselx line, runs the SETUP/ACCESS
//   handshake and serves an 8-word register bank (scratch, control, timer, status) back over Prdata.
// - No PREADY: every transfer completes in exactly two PCLK cycles. Read data is registered and stable for
//   the whole ACCESS phase. Also the standard bench-side slave for bridge regressions.
// PARAMETERS
// - SEL_IDX      0         which Pselx bit selects this slave (0..2)
// - SCRATCH_RST  32'h0     reset value of scratch words 0..3
// - CMP_RST      32'hFFFF_FFFF  reset value of CMP
// PORTS
// - clk      in   1   sole clock, rising edge
// - rst      in   1   synchronous, active-high reset
// - Pselx    in   3   one-hot slave select from bridge; this slave uses Pselx[SEL_IDX]
// - Penable  in   1   ACCESS-phase strobe
// - Pwrite   in   1   1 = write, 0 = read
// - Paddr    in   32  byte address; only Paddr[4:2] decoded, rest ignored
// - Pwdata   in   32  write data
// - Prdata   out  32  registered read data
// - irq      out  1   STATUS[0] & CTRL[1], registered
// - perr     out  1   mirror of STATUS[1] (sticky protocol error)
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): state=IDLE, Prdata=0, irq=0, perr=0, scratch=SCRATCH_RST, CTRL=0,
//   COUNT=0, CMP=CMP_RST, STATUS=0. rst mid-transfer aborts it: no write commits, Prdata=0 next cycle.
// - sel = Pselx[SEL_IDX]. FSM states IDLE, SETUP, ACCESS:
//   IDLE  : sel&!Penable -> SETUP; sel&Penable -> IDLE, set STATUS[1]; else IDLE.
//   SETUP : sel&Penable -> ACCESS; else -> IDLE, set STATUS[1] (setup not followed by access).
//   ACCESS: sel&!Penable -> SETUP (back-to-back); sel&Penable -> IDLE, set STATUS[1]; !sel -> IDLE.
// - In the SETUP cycle latch addr_q=Paddr[4:2], wr_q=Pwrite. In the SETUP->ACCESS cycle, Paddr[4:2]!=addr_q
//   or Pwrite!=wr_q sets STATUS[1] and suppresses that transfer's write.
// - Read: at end of SETUP cycle with !Pwrite, Prdata <= reg[Paddr[4:2]]; held through ACCESS; cleared to 0 when
//   returning to IDLE. Latency: data valid on first ACCESS cycle (1 cycle after SETUP).
// - Write: commits at the posedge ending the SETUP->ACCESS cycle (sel&Penable&Pwrite), using latched addr, Pwdata
//   as sampled on that edge. Visible to reads starting on the next SETUP.
// - Register map (word index): 0-3 SCRATCH RW; 4 CTRL RW bits[1:0] (b0 cnt_en, b1 irq_en), upper bits read 0;
//   5 COUNT RO (writes ignored); 6 CMP RW; 7 STATUS: b0 match, b1 proto_err, W1C, upper read 0.
// - COUNT: +1 per cycle while CTRL[0]; wraps 32'hFFFF_FFFF -> 0 silently. When COUNT==CMP and CTRL[0], STATUS[0]
//   sets on next edge. Write to CTRL takes effect the cycle after commit.
// - Simultaneous events: set beats W1C clear on same edge for both STATUS bits; read of STATUS samples
//   pre-update value; COUNT read returns value at the SETUP edge.
// - irq/perr are registered from STATUS, one cycle behind it.
// STRUCTURE
// - Shared package apb_pkg: state enum {IDLE,SETUP,ACCESS}, register word indices (REG_SCR0..REG_STATUS),
//   CTRL/STATUS bit positions; bridge testbenches import the same constants.
// - One sub-module apb_timer_core: COUNT, CMP compare, match pulse, cnt_en input; top keeps FSM, decode, regs.
// TESTING
// - Reset: drive rst=1 two cycles -> Prdata=0, irq=0, perr=0; read word 0 -> SCRATCH_RST, word 6 -> FFFF_FFFF.
// - Write 32'hDEAD_BEEF to Paddr 0x08 (SETUP,ACCESS), then read 0x08 -> Prdata=DEAD_BEEF during ACCESS.
// - Back-to-back: write 0x04=1 then read 0x04 with ACCESS->SETUP, no idle -> reads 0x0000_0001, no perr.
// - Timer: CMP=5, CTRL=3 -> STATUS[0] set 6 cycles after CTRL commit, irq 1 cycle later; W1C STATUS=1 clears irq.
// - Protocol: Penable=1 with sel in IDLE -> perr=1, no write; also SETUP then sel dropped -> perr=1; W1C 2 clears.
// - Addr change SETUP 0x00 -> ACCESS 0x04 on write 0x1234 -> both words unchanged, perr=1; Pselx on other bit ignored.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants for the APB register slave: FSM states, register word
// indices and CTRL/STATUS bit positions. Bridge benches import this too.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Register word indices (Paddr[4:2])
  localparam logic [2:0] REG_SCR0   = 3'd0;
  localparam logic [2:0] REG_SCR1   = 3'd1;
  localparam logic [2:0] REG_SCR2   = 3'd2;
  localparam logic [2:0] REG_SCR3   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;
  localparam logic [2:0] REG_CMP    = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  // CTRL / STATUS bit positions
  localparam int CTRL_CNT_EN      = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int STATUS_MATCH     = 0;
  localparam int STATUS_PROTO_ERR = 1;

  // Byte address of a register word
  function automatic logic [31:0] reg_addr(input logic [2:0] idx);
    return {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB2 bus bundle between the bridge (master) and a register slave.
// Handshake: a transfer is one SETUP cycle (Pselx bit high, Penable low)
// followed by exactly one ACCESS cycle (same select, Penable high, address
// and direction unchanged). There is no ready/wait signal, so every transfer
// takes exactly two clocks; Prdata is valid for the whole ACCESS cycle.
interface apb_slave_regs_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_timer_core.sv
// Free-running 32-bit counter with compare. COUNT advances while cnt_en is
// high and wraps silently; match flags COUNT==CMP while enabled.
module apb_timer_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_en,
  input  logic [31:0] cmp,
  output logic [31:0] count,
  output logic        match
);

  // Counter: +1 per enabled cycle, natural wrap from all-ones to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (cnt_en) begin
      count <= count + 32'd1;
    end
  end

  // Compare uses the pre-increment value, so STATUS sets on the next edge
  assign match = cnt_en && (count == cmp);

endmodule

// File: rtl/apb_slave_regs.sv
// APB2 register slave: SETUP/ACCESS tracking, protocol-error detection,
// 8-word register bank (scratch, CTRL, COUNT, CMP, STATUS) and irq/perr.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int          SEL_IDX     = 0,
  parameter logic [31:0] SCRATCH_RST = 32'h0,
  parameter logic [31:0] CMP_RST     = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  apb_slave_regs_if.slave bus,
  output logic            irq,
  output logic            perr,
  output state_e          fsm_state
);

  logic        sel;
  logic [2:0]  addr_in;
  state_e      state;
  state_e      state_nxt;
  logic [2:0]  addr_q;
  logic        wr_q;
  logic        xfer_mismatch;
  logic        setup_go;
  logic        wr_commit;
  logic        proto_set;
  logic [31:0] scratch [4];
  logic [1:0]  ctrl;
  logic [31:0] cmp;
  logic [1:0]  status;
  logic [31:0] count;
  logic        match;
  logic [31:0] rd_data;
  logic [1:0]  w1c;
  logic        unused_bits;

  assign sel       = bus.Pselx[SEL_IDX];
  assign addr_in   = bus.Paddr[4:2];
  assign fsm_state = state;

  // Only the selected Pselx bit and Paddr[4:2] matter to this slave
  assign unused_bits = ^{bus.Pselx, bus.Paddr[31:5], bus.Paddr[1:0]};

  // ACCESS must repeat the address and direction presented in SETUP
  assign xfer_mismatch = (addr_in != addr_q) || (bus.Pwrite != wr_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (sel && !bus.Penable) ? SETUP  : IDLE;
      SETUP:   state_nxt = (sel &&  bus.Penable) ? ACCESS : IDLE;
      ACCESS:  state_nxt = (sel && !bus.Penable) ? SETUP  : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: setup capture, write commit and protocol-error strobe
  always_comb begin
    setup_go  = 1'b0;
    wr_commit = 1'b0;
    proto_set = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !bus.Penable) setup_go  = 1'b1;
        if (sel &&  bus.Penable) proto_set = 1'b1;
      end
      SETUP: begin
        if (sel && bus.Penable) begin
          if (xfer_mismatch) proto_set = 1'b1;
          else if (wr_q)     wr_commit = 1'b1;
        end else begin
          proto_set = 1'b1;
        end
      end
      ACCESS: begin
        if (sel && !bus.Penable)     setup_go  = 1'b1;
        else if (sel && bus.Penable) proto_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture address and direction during the SETUP cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else if (setup_go) begin
      addr_q <= addr_in;
      wr_q   <= bus.Pwrite;
    end
  end

  // Read mux over the register map; reserved CTRL/STATUS bits read zero
  always_comb begin
    rd_data = '0;
    case (addr_in)
      REG_SCR0, REG_SCR1, REG_SCR2, REG_SCR3: rd_data = scratch[addr_in[1:0]];
      REG_CTRL:   rd_data = {30'd0, ctrl};
      REG_COUNT:  rd_data = count;
      REG_CMP:    rd_data = cmp;
      REG_STATUS: rd_data = {30'd0, status};
      default:    rd_data = '0;
    endcase
  end

  // Read data: loaded at the end of SETUP, held through ACCESS, zero in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Prdata <= '0;
    end else if (setup_go) begin
      bus.Prdata <= bus.Pwrite ? 32'd0 : rd_data;
    end else if (state_nxt == IDLE) begin
      bus.Prdata <= '0;
    end
  end

  // Scratch words 0..3
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) scratch[i] <= SCRATCH_RST;
    end else if (wr_commit && !addr_q[2]) begin
      scratch[addr_q[1:0]] <= bus.Pwdata;
    end
  end

  // CTRL and CMP; COUNT is read-only so writes to it are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      cmp  <= CMP_RST;
    end else if (wr_commit) begin
      if (addr_q == REG_CTRL) ctrl <= bus.Pwdata[1:0];
      if (addr_q == REG_CMP)  cmp  <= bus.Pwdata;
    end
  end

  assign w1c = (wr_commit && addr_q == REG_STATUS) ? bus.Pwdata[1:0] : 2'b00;

  // STATUS: sticky bits, write-one-to-clear, a new event wins over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
    end else begin
      status[STATUS_MATCH]     <= match     | (status[STATUS_MATCH]     & ~w1c[STATUS_MATCH]);
      status[STATUS_PROTO_ERR] <= proto_set | (status[STATUS_PROTO_ERR] & ~w1c[STATUS_PROTO_ERR]);
    end
  end

  // irq/perr follow STATUS one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      irq  <= 1'b0;
      perr <= 1'b0;
    end else begin
      irq  <= status[STATUS_MATCH] & ctrl[CTRL_IRQ_EN];
      perr <= status[STATUS_PROTO_ERR];
    end
  end

  apb_timer_core u_timer (
    .clk    (clk),
    .rst    (rst),
    .cnt_en (ctrl[CTRL_CNT_EN]),
    .cmp    (cmp),
    .count  (count),
    .match  (match)
  );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: directed protocol/timer scenarios
// plus randomized transfers checked against a word-array register model.
module tb_apb_slave_regs;
  import apb_pkg::*;

  localparam int          SEL_IDX_TB = 2;
  localparam logic [2:0]  SEL_MASK   = 3'b100;
  localparam logic [2:0]  OTHER_MASK = 3'b001;
  localparam logic [31:0] SCR_RST_TB = 32'h1357_9BDF;
  localparam logic [31:0] CMP_RST_TB = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   irq;
  logic   perr;
  state_e fsm_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_regs_if bus_if ();

  apb_slave_regs #(
    .SEL_IDX     (SEL_IDX_TB),
    .SCRATCH_RST (SCR_RST_TB),
    .CMP_RST     (CMP_RST_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .irq       (irq),
    .perr      (perr),
    .fsm_state (fsm_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < 4; i++) mdl[i] = SCR_RST_TB;
    mdl[4] = 32'd0;
    mdl[5] = 32'd0;
    mdl[6] = CMP_RST_TB;
    mdl[7] = 32'd0;
  endfunction

  // Register-map rules: CTRL keeps 2 bits, COUNT ignores writes, STATUS is W1C
  function automatic void mdl_write(input logic [2:0] idx, input logic [31:0] data);
    case (idx)
      3'd4:    mdl[4] = data & 32'h3;
      3'd5:    ;
      3'd7:    mdl[7] = mdl[7] & ~(data & 32'h3);
      default: mdl[idx] = data;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus idle; other slaves may be active on the remaining Pselx bits
  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.Pselx   = 3'($urandom_range(0, 7)) & ~SEL_MASK;
      bus_if.Penable = 1'($urandom_range(0, 1));
      bus_if.Pwrite  = 1'($urandom_range(0, 1));
      bus_if.Paddr   = $urandom;
      bus_if.Pwdata  = $urandom;
      tick();
    end
  endtask

  task automatic drive(input logic [2:0] psel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    bus_if.Pselx   = psel;
    bus_if.Penable = en;
    bus_if.Pwrite  = wr;
    bus_if.Paddr   = addr;
    bus_if.Pwdata  = data;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    drive(SEL_MASK, 1'b0, 1'b1, addr, data);
    tick();
    bus_if.Penable = 1'b1;
    tick();
    mdl_write(addr[4:2], data);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output int setup_cyc);
    drive(SEL_MASK, 1'b0, 1'b0, addr, $urandom);
    tick();
    setup_cyc = cyc;
    bus_if.Penable = 1'b1;
    @(negedge clk);
    data = bus_if.Prdata;
    tick();
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr);
    logic [31:0] got;
    int          sc;
    exp_q.push_back(mdl[addr[4:2]]);
    apb_read(addr, got, sc);
    check(tag, got, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  idx;
    int          sc;
    int          c0;
    int          first_irq;

    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    mdl_reset();
    tick();
    tick();
    rst = 1'b0;
    check("rst_prdata", bus_if.Prdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    check_read("rst_scr0", reg_addr(REG_SCR0));
    check_read("rst_cmp", reg_addr(REG_CMP));
    go_idle(1);

    // Plain write then read
    apb_write(32'h08, 32'hDEAD_BEEF);
    go_idle(1);
    check_read("scr2_rd", 32'h08);
    go_idle(1);

    // Back-to-back write then read, no idle between
    apb_write(32'h04, 32'h1);
    check_read("b2b_rd", 32'h04);
    go_idle(2);
    check("b2b_perr", 32'(perr), 32'd0);

    // Timer: CMP=5, enable counter and irq
    apb_write(reg_addr(REG_CMP), 32'd5);
    apb_write(reg_addr(REG_CTRL), 32'hFFFF_FFF3);
    c0 = cyc;
    first_irq = 0;
    for (int k = 1; k <= 20; k++) begin
      go_idle(1);
      if (irq && first_irq == 0) first_irq = k;
    end
    check("irq_latency", 32'(first_irq), 32'd7);
    mdl[7] = mdl[7] | 32'h1;
    check_read("status_match", reg_addr(REG_STATUS));
    check_read("ctrl_rd", reg_addr(REG_CTRL));
    apb_read(reg_addr(REG_COUNT), got, sc);
    check("count_at_setup", got, 32'(sc - c0 - 1));
    apb_write(reg_addr(REG_STATUS), 32'h1);
    go_idle(2);
    check("irq_cleared", 32'(irq), 32'd0);
    check_read("status_clr", reg_addr(REG_STATUS));
    apb_write(reg_addr(REG_CTRL), 32'h0);
    go_idle(1);

    // Penable high while selected in IDLE
    drive(SEL_MASK, 1'b1, 1'b1, 32'h0, 32'h0BAD_0BAD);
    tick();
    go_idle(2);
    mdl[7] = mdl[7] | 32'h2;
    check("perr_idle_en", 32'(perr), 32'd1);
    check_read("w0_idle_en", 32'h0);
    check_read("status_proto", reg_addr(REG_STATUS));
    apb_write(reg_addr(REG_STATUS), 32'h2);
    go_idle(2);
    check("perr_clr1", 32'(perr), 32'd0);

    // SETUP then select dropped
    drive(SEL_MASK, 1'b0, 1'b1, 32'h0, 32'h0BAD_0BAD);
    tick();
    go_idle(2);
    mdl[7] = mdl[7] | 32'h2;
    check("perr_sel_drop", 32'(perr), 32'd1);
    check_read("w0_sel_drop", 32'h0);
    apb_write(reg_addr(REG_STATUS), 32'h2);
    go_idle(2);
    check("perr_clr2", 32'(perr), 32'd0);

    // Address changes between SETUP and ACCESS
    drive(SEL_MASK, 1'b0, 1'b1, 32'h0, 32'h0000_1234);
    tick();
    drive(SEL_MASK, 1'b1, 1'b1, 32'h4, 32'h0000_1234);
    tick();
    go_idle(2);
    mdl[7] = mdl[7] | 32'h2;
    check("perr_addr_chg", 32'(perr), 32'd1);
    check_read("w0_addr_chg", 32'h0);
    check_read("w1_addr_chg", 32'h4);
    apb_write(reg_addr(REG_STATUS), 32'h2);
    go_idle(2);

    // Transfer addressed to a different slave
    drive(OTHER_MASK, 1'b0, 1'b1, 32'h0, 32'h5555_5555);
    tick();
    bus_if.Penable = 1'b1;
    tick();
    go_idle(2);
    check("perr_other", 32'(perr), 32'd0);
    check_read("w0_other", 32'h0);
    go_idle(1);

    // Reset during the ACCESS phase of a read
    drive(SEL_MASK, 1'b0, 1'b0, 32'h08, 32'h0);
    tick();
    bus_if.Penable = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_prdata", bus_if.Prdata, 32'd0);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    mdl_reset();
    go_idle(1);
    check_read("abort_scr2", 32'h08);
    go_idle(1);

    // Randomized transfers against the register model
    for (int t = 0; t < 80; t++) begin
      idx  = 3'($urandom_range(0, 7));
      data = $urandom;
      if (idx == REG_CTRL) data[0] = 1'b0;
      addr = ($urandom & 32'hFFFF_FFE0) | {27'd0, idx, 2'b00} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) apb_write(addr, data);
      else check_read("rand_rd", addr);
      sc = $urandom_range(0, 2);
      if (sc > 0) go_idle(sc);
    end
    go_idle(2);
    check("rand_perr", 32'(perr), 32'd0);
    check("rand_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) check_read("final_sweep", reg_addr(3'(i)));
    go_idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
